// File: rtl/bol_readout_seq.sv
// bol_readout_seq: bolometer frame/row timing and datavalid delay path.
// Define BOL_LINE1_CHECK_EN to enable the first-line marker check.
module bol_readout_seq #(
    parameter int ROWS     = 480,
    parameter int COLS     = 640,
    parameter int NUM_CHAN = 8,
    parameter int HBLANK   = 20,
    parameter int CNT_W    = 12,
    parameter int ROW_W    = 10,
    parameter int IT_W     = 10
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             ENABLE,
    input  logic             SINGLE,
    input  logic [IT_W-1:0]  INT_TIME,
    input  logic [4:0]       DV_DELAY,
    output logic             BL_MC,
    output logic             BL_RESET,
    output logic             BL_INT,
    output logic             BL_SERDATA,
    input  logic             BL_DATAVALID,
    input  logic             BL_LINE1,
    input  logic             BL_ERROR,
    output logic             BUF_WR_EN,
    output logic             BUF_WR_STB,
    output logic             BUF_SEL,
    output logic [ROW_W-1:0] CNT_ROW,
    output logic             FRAME_START,
    output logic             FRAME_DONE,
    output logic [1:0]       STATUS_ERR
);

    localparam int PIX_ROW = COLS / NUM_CHAN;
    localparam int PERIOD  = PIX_ROW + HBLANK;
    localparam int LEN0    = PIX_ROW + 3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FRST,
        S_ROW0,
        S_ROWN
    } state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] col, col_n;
    logic [ROW_W-1:0] row, row_n;
    logic             en_q;
    logic             go;
    logic             start_n;
    logic             done_n;
    logic             rst_d;
    logic             int_d;
    logic [31:0]      row_len;
    logic [31:0]      it_req;
    logic [31:0]      it_lim;
    logic [31:0]      it_eff;
    logic [31:0]      dv_sr;
    logic             wr_en_q;
    logic             err_st;

    assign go     = SINGLE ? (ENABLE & ~en_q) : ENABLE;
    assign it_req = 32'(INT_TIME);
    assign BL_MC  = CLK & en_q;

    // state, column and row counters
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state <= S_IDLE;
            col   <= '0;
            row   <= '0;
            en_q  <= 1'b0;
        end else begin
            state <= state_n;
            col   <= col_n;
            row   <= row_n;
            if (state == S_IDLE)
                en_q <= ENABLE;
        end
    end

    // next state and counter decode of the sensor controls
    always_comb begin
        state_n = state;
        col_n   = col;
        row_n   = row;
        start_n = 1'b0;
        done_n  = 1'b0;
        rst_d   = 1'b0;
        row_len = '0;
        unique case (state)
            S_IDLE: begin
                if (go) begin
                    state_n = S_FRST;
                    col_n   = '0;
                    start_n = 1'b1;
                end
            end
            S_FRST: begin
                rst_d = (col == '0);
                if (col == CNT_W'(1)) begin
                    state_n = S_ROW0;
                    col_n   = '0;
                    row_n   = '0;
                end else begin
                    col_n = col + CNT_W'(1);
                end
            end
            S_ROW0: begin
                row_len = 32'(LEN0);
                if (col == CNT_W'(LEN0 - 1)) begin
                    state_n = S_ROWN;
                    col_n   = '0;
                    row_n   = ROW_W'(1);
                end else begin
                    col_n = col + CNT_W'(1);
                end
            end
            S_ROWN: begin
                if (row < ROW_W'(ROWS))
                    row_len = 32'(PERIOD);
                if (col == CNT_W'(PERIOD - 1)) begin
                    col_n = '0;
                    if (row == ROW_W'(ROWS + 1)) begin
                        done_n = 1'b1;
                        if (!SINGLE && ENABLE) begin
                            state_n = S_FRST;
                            start_n = 1'b1;
                        end else begin
                            state_n = S_IDLE;
                        end
                    end else begin
                        row_n = row + ROW_W'(1);
                    end
                end else begin
                    col_n = col + CNT_W'(1);
                end
            end
            default: state_n = S_IDLE;
        endcase
        it_lim = row_len - 32'd1;
        it_eff = (it_req > it_lim) ? it_lim : it_req;
        int_d  = (row_len != '0) && (it_eff != '0)
                 && (32'(col) >= row_len - it_eff);
    end

    // registered sensor controls and frame pulses
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            BL_RESET    <= 1'b0;
            BL_INT      <= 1'b0;
            BL_SERDATA  <= 1'b1;
            FRAME_START <= 1'b0;
            FRAME_DONE  <= 1'b0;
        end else begin
            BL_RESET    <= rst_d;
            BL_INT      <= int_d;
            BL_SERDATA  <= 1'b0;
            FRAME_START <= start_n;
            FRAME_DONE  <= done_n;
        end
    end

    assign BUF_WR_EN  = dv_sr[DV_DELAY];
    assign BUF_WR_STB = BUF_WR_EN & (row >= ROW_W'(2));
    assign CNT_ROW    = (row >= ROW_W'(2)) ? row - ROW_W'(2) : '0;

    // datavalid delay line and ping-pong select
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            dv_sr   <= '0;
            wr_en_q <= 1'b0;
            BUF_SEL <= 1'b0;
        end else begin
            dv_sr   <= {dv_sr[30:0], BL_DATAVALID};
            wr_en_q <= BUF_WR_EN;
            if (state == S_IDLE)
                BUF_SEL <= 1'b0;
            else if (wr_en_q && !BUF_WR_EN)
                BUF_SEL <= ~BUF_SEL;
        end
    end

    // sticky sensor error, cleared as each frame starts
    always_ff @(posedge CLK) begin
        if (!RESET_N)
            err_st <= 1'b0;
        else if (start_n)
            err_st <= 1'b0;
        else if (BL_ERROR && state != S_IDLE)
            err_st <= 1'b1;
    end

    assign STATUS_ERR[0] = err_st;

`ifdef BOL_LINE1_CHECK_EN
    logic [31:0] ln_sr;
    logic        row2_seen;
    logic        err_l1;
    logic        wr_rise;

    assign wr_rise = BUF_WR_EN & ~wr_en_q;

    // first-line marker must accompany only the first row-2 write
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            ln_sr     <= '0;
            row2_seen <= 1'b0;
            err_l1    <= 1'b0;
        end else begin
            ln_sr <= {ln_sr[30:0], BL_LINE1};
            if (start_n) begin
                row2_seen <= 1'b0;
                err_l1    <= 1'b0;
            end else if (wr_rise) begin
                if (row == ROW_W'(2) && !row2_seen) begin
                    row2_seen <= 1'b1;
                    if (!ln_sr[DV_DELAY])
                        err_l1 <= 1'b1;
                end else if (ln_sr[DV_DELAY]) begin
                    err_l1 <= 1'b1;
                end
            end
        end
    end

    assign STATUS_ERR[1] = err_l1;
`else
    logic unused_line1;

    assign unused_line1  = BL_LINE1;
    assign STATUS_ERR[1] = 1'b0;
`endif

endmodule
